// File: rtl/rv32i_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv32i_pkg: RV32I format selects, opcodes and immediate helpers       |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package rv32i_pkg;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;

   // True when v is representable as an n-bit two's-complement value.
   function automatic logic fits_signed(input logic [31:0] v, input int n);
      logic signed [31:0] t;
      t = $signed(v) >>> (n - 1);
      return (t == '0) || (t == '1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_pack: combinational RV32I field packer with immediate check    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module instr_pack
   import rv32i_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] instr,
   output logic        err
);

   logic [31:0] word;
   logic        legal;

   always_comb begin
      word  = '0;
      legal = 1'b1;
      case (fmt)
         FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            word  = {imm[11:0], rs1, funct3, rd, opcode};
            legal = fits_signed(imm, 12);
         end
         FMT_S: begin
            word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            legal = fits_signed(imm, 12);
         end
         // 13-bit signed and even gives the [-4096, 4094] window.
         FMT_B: begin
            word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            legal = fits_signed(imm, 13) && !imm[0];
         end
         FMT_U: begin
            word  = {imm[31:12], rd, opcode};
            legal = (imm[11:0] == 12'h000);
         end
         FMT_J: begin
            word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            legal = fits_signed(imm, 21) && !imm[0];
         end
         default: legal = 1'b0;
      endcase
      instr = legal ? word : NOP_INSTR;
      err   = !legal;
   end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_encoder: pipelined RV32I encoder with address tag and err count|
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module instr_encoder
   import rv32i_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          in_fmt,
   input  logic [6:0]          in_opcode,
   input  logic [4:0]          in_rd,
   input  logic [4:0]          in_rs1,
   input  logic [4:0]          in_rs2,
   input  logic [2:0]          in_funct3,
   input  logic [6:0]          in_funct7,
   input  logic [31:0]         in_imm,
   input  logic                addr_load,
   input  logic [ADDR_W-1:0]   addr_base,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_instr,
   output logic [ADDR_W-1:0]   out_addr,
   output logic                out_err,
   output logic [ERRCNT_W-1:0] err_count
);

   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] this_addr;
   logic [31:0]       pack_instr;
   logic              pack_err;
   logic              accept;

   instr_pack u_pack (
      .fmt    (in_fmt),
      .opcode (in_opcode),
      .rd     (in_rd),
      .rs1    (in_rs1),
      .rs2    (in_rs2),
      .funct3 (in_funct3),
      .funct7 (in_funct7),
      .imm    (in_imm),
      .instr  (pack_instr),
      .err    (pack_err)
   );

   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   // A load coinciding with an accept tags that very word with the base.
   assign this_addr = addr_load ? addr_base : wr_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_addr  <= '0;
         out_err   <= 1'b0;
         err_count <= '0;
         wr_addr   <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_instr <= pack_instr;
            out_addr  <= this_addr;
            out_err   <= pack_err;
            wr_addr   <= this_addr + ADDR_W'(1);
            if (pack_err && (err_count != '1))
               err_count <= err_count + ERRCNT_W'(1);
         end else begin
            if (out_ready)
               out_valid <= 1'b0;
            if (addr_load)
               wr_addr <= addr_base;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_instr_encoder: directed + randomized bench with behavioural model |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_instr_encoder;
   import rv32i_pkg::*;

   localparam int AW = 4;
   localparam int EW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    in_fmt = '0;
   logic [6:0]    in_opcode = '0;
   logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]    in_funct3 = '0;
   logic [6:0]    in_funct7 = '0;
   logic [31:0]   in_imm = '0;
   logic          addr_load = 1'b0;
   logic [AW-1:0] addr_base = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_instr;
   logic [AW-1:0] out_addr;
   logic          out_err;
   logic [EW-1:0] err_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(AW), .ERRCNT_W(EW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .addr_load(addr_load), .addr_base(addr_base), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
      .out_err(out_err), .err_count(err_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference encoder: range rules on the signed value, bit fields placed by arithmetic.
   function automatic void model_enc(input logic [2:0] f, input logic [6:0] op,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] imm,
                                     output logic [31:0] w, output logic e);
      int          si;
      bit          ok;
      logic [31:0] base;
      si   = $signed(imm);
      base = 32'(op) + (32'(f3) << 12) + (32'(rs1) << 15);
      ok   = 1'b1;
      w    = '0;
      case (f)
         3'd0: w = base + (32'(rd) << 7) + (32'(rs2) << 20) + (32'(f7) << 25);
         3'd1: begin
            ok = (si >= -2048) && (si <= 2047);
            w  = base + (32'(rd) << 7) + ((imm & 32'hFFF) << 20);
         end
         3'd2: begin
            ok = (si >= -2048) && (si <= 2047);
            w  = base + ((imm & 32'h1F) << 7) + (32'(rs2) << 20) + (((imm >> 5) & 32'h7F) << 25);
         end
         3'd3: begin
            ok = (si >= -4096) && (si <= 4094) && ((si % 2) == 0);
            w  = base + (((imm >> 11) & 1) << 7) + (((imm >> 1) & 32'hF) << 8)
                 + (32'(rs2) << 20) + (((imm >> 5) & 32'h3F) << 25) + (((imm >> 12) & 1) << 31);
         end
         3'd4: begin
            ok = ((imm % 4096) == 0);
            w  = (imm & 32'hFFFF_F000) + (32'(rd) << 7) + 32'(op);
         end
         3'd5: begin
            ok = (si >= -(1 << 20)) && (si <= (1 << 20) - 2) && ((si % 2) == 0);
            w  = 32'(op) + (32'(rd) << 7) + (((imm >> 12) & 32'hFF) << 12) + (((imm >> 11) & 1) << 20)
                 + (((imm >> 1) & 32'h3FF) << 21) + (((imm >> 20) & 1) << 31);
         end
         default: ok = 1'b0;
      endcase
      if (!ok) w = 32'h0000_0013;
      e = !ok;
   endfunction

   bit            m_valid;
   logic [31:0]   m_instr;
   logic [AW-1:0] m_addr, m_wr, m_a;
   logic          m_err, m_e;
   logic [31:0]   m_w;
   int            m_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 0; m_instr = '0; m_addr = '0; m_err = 0; m_cnt = 0; m_wr = '0;
      end else if (in_valid && (!m_valid || out_ready)) begin
         model_enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, m_w, m_e);
         m_a     = addr_load ? addr_base : m_wr;
         m_valid = 1;
         m_instr = m_w;
         m_err   = m_e;
         m_addr  = m_a;
         m_wr    = m_a + 1'b1;
         if (m_e && m_cnt < (1 << EW) - 1) m_cnt++;
      end else begin
         if (out_ready) m_valid = 0;
         if (addr_load) m_wr = addr_base;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("cmp_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
         chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
         chk("cmp_err_count", 32'(err_count), 32'(m_cnt));
         if (m_valid) begin
            chk("cmp_out_instr", out_instr, m_instr);
            chk("cmp_out_addr", 32'(out_addr), 32'(m_addr));
            chk("cmp_out_err", 32'(out_err), 32'(m_err));
         end
      end
   end

   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm,
                       input logic ld, input logic [AW-1:0] base);
      @(posedge clk); #1;
      in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm;
      in_valid = 1'b1; out_ready = 1'b1; addr_load = ld; addr_base = base;
      @(posedge clk); #1;
      in_valid = 1'b0; addr_load = 1'b0;
   endtask

   int bounds [17] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098,
                       -1048576, 1048574, 1048576, -1048578, 0, 1, 2, 3};

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_addr", 32'(out_addr), 0);
      chk("rst_err_count", 32'(err_count), 0);

      send(FMT_I, 7'h13, 1, 0, 0, 0, 0, 32'd5, 0, 0);
      chk("lit_addi", out_instr, 32'h0050_0093);
      chk("lit_addi_err", 32'(out_err), 0);
      chk("lit_addi_addr", 32'(out_addr), 0);
      send(FMT_S, 7'h23, 0, 1, 2, 2, 0, 32'd8, 0, 0);
      chk("lit_sw", out_instr, 32'h0020_A423);
      send(FMT_B, 7'h63, 0, 0, 0, 0, 0, -32'sd4, 0, 0);
      chk("lit_beq", out_instr, 32'hFE00_0EE3);
      send(FMT_J, 7'h6F, 1, 0, 0, 0, 0, 32'd2048, 0, 0);
      chk("lit_jal", out_instr, 32'h0010_00EF);
      send(FMT_U, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5000, 0, 0);
      chk("lit_lui", out_instr, 32'h1234_52B7);
      chk("lit_lui_addr", 32'(out_addr), 4);
      send(FMT_I, 7'h13, 1, 0, 0, 0, 0, 32'd2048, 0, 0);
      chk("lit_i_ovf", out_instr, 32'h0000_0013);
      chk("lit_i_ovf_err", 32'(out_err), 1);
      send(FMT_B, 7'h63, 0, 0, 0, 0, 0, 32'd3, 0, 0);
      chk("lit_b_odd_err", 32'(out_err), 1);
      send(3'd7, 7'h13, 0, 0, 0, 0, 0, 32'd0, 0, 0);
      chk("lit_fmt7_err", 32'(out_err), 1);
      chk("lit_err_count3", 32'(err_count), 3);

      // Backpressure: A accepted with counter reload, B stalled behind it.
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; addr_load = 1'b1; addr_base = '0;
      in_fmt = FMT_R; in_opcode = 7'h33; in_rd = 1; in_rs1 = 2; in_rs2 = 3;
      in_funct3 = 0; in_funct7 = 7'h20;
      @(posedge clk); #1;
      addr_load = 1'b0;
      in_fmt = FMT_I; in_opcode = 7'h13; in_rd = 2; in_rs1 = 0; in_funct3 = 0; in_imm = 32'hFFFF_FFFF;
      chk("bp_a_instr", out_instr, 32'h4031_00B3);
      chk("bp_a_addr", 32'(out_addr), 0);
      chk("bp_in_ready0", 32'(in_ready), 0);
      @(posedge clk); #1;
      chk("bp_a_hold", out_instr, 32'h4031_00B3);
      chk("bp_in_ready0_b", 32'(in_ready), 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_b_instr", out_instr, 32'hFFF0_0113);
      chk("bp_b_addr", 32'(out_addr), 1);

      send(FMT_R, 7'h33, 1, 2, 3, 0, 0, 0, 1, 4'd15);
      chk("wrap_addr15", 32'(out_addr), 15);
      send(FMT_R, 7'h33, 1, 2, 3, 0, 0, 0, 0, 0);
      chk("wrap_addr0", 32'(out_addr), 0);

      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_fmt = FMT_I; in_imm = 32'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("rst_pre_valid", 32'(out_valid), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_out_instr", out_instr, 0);
      chk("arst_out_addr", 32'(out_addr), 0);
      chk("arst_out_err", 32'(out_err), 0);
      chk("arst_err_count", 32'(err_count), 0);
      chk("arst_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1 rst = 1'b0;
      send(FMT_I, 7'h13, 1, 0, 0, 0, 0, 32'd5, 0, 0);
      chk("post_rst_addr", 32'(out_addr), 0);

      for (int n = 0; n < 2000; n++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 4) != 0;
         addr_load = ($urandom % 16) == 0;
         addr_base = AW'($urandom);
         in_fmt    = 3'($urandom);
         in_opcode = 7'($urandom);
         in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
         in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
         case ($urandom % 4)
            0: in_imm = 32'($urandom_range(0, 10000)) - 32'd5000;
            1: in_imm = 32'(bounds[$urandom % 17]);
            2: in_imm = $urandom;
            default: in_imm = ($urandom & 32'hFFFF_F000) | 32'($urandom % 2);
         endcase
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
